// File: rtl/btn_latch_pkg.sv
// btn_latch_pkg: shared state encoding and index constants for the button latch
package btn_latch_pkg;
  typedef enum logic [1:0] {ST_CLR = 2'd0, ST_SET = 2'd1, ST_CONFLICT = 2'd2} state_e;
  localparam int LED_Q        = 0;
  localparam int LED_QN       = 1;
  localparam int LED_CONFLICT = 2;
  localparam int LED_SETP     = 3;
  localparam int LED_RSTP     = 4;
  localparam int BTN_SET      = 0;
  localparam int BTN_RST      = 1;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus stable-count debounce for one active-low button
module btn_debounce #(
  parameter int DEB_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed
);
  localparam int CW = $clog2(DEB_CYCLES);
  logic [1:0]    sync_q, sync_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl, hit;
  always_comb begin
    sync_d   = {sync_q[0], btn_n};
    lvl      = ~sync_q[1];
    hit      = cnt_q == CW'(DEB_CYCLES - 1);
    cnt_d    = (lvl == stable_q || hit) ? '0 : cnt_q + 1'b1;
    stable_d = (lvl != stable_q && hit) ? lvl : stable_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end
  assign pressed = stable_q;
endmodule

// File: rtl/btn_latch_ctrl.sv
// btn_latch_ctrl: debounced set/reset latch with conflict detection and status LEDs
module btn_latch_ctrl
  import btn_latch_pkg::*;
#(
  parameter int DEB_CYCLES = 270000,
  parameter int BLINK_HALF = 6750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn,
  output logic       q,
  output logic       q_n,
  output logic [4:0] led
);
  localparam int BW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
  logic          set_p, rst_p;
  state_e        state_q, state_d;
  logic          q_q, q_d, qn_q, qn_d, blink_q, blink_d, setp_q, rstp_q;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          bwrap;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk(clk), .rst(rst), .btn_n(btn[BTN_SET]), .pressed(set_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
    .clk(clk), .rst(rst), .btn_n(btn[BTN_RST]), .pressed(rst_p)
  );
  // both released while in conflict falls back to cleared rather than holding
  always_comb begin
    state_d = (set_p && rst_p) ? ST_CONFLICT :
              set_p ? ST_SET :
              rst_p ? ST_CLR :
              (state_q == ST_CONFLICT) ? ST_CLR : state_q;
    q_d     = state_d == ST_SET;
    qn_d    = state_d == ST_CLR;
    bwrap   = bcnt_q == BW'(BLINK_HALF - 1);
    bcnt_d  = '0;
    blink_d = 1'b0;
    if (state_d == ST_CONFLICT && state_q == ST_CONFLICT) begin
      bcnt_d  = bwrap ? '0 : bcnt_q + 1'b1;
      blink_d = bwrap ? ~blink_q : blink_q;
    end else if (state_d == ST_CONFLICT) begin
      blink_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLR;
      q_q     <= 1'b0;
      qn_q    <= 1'b1;
      blink_q <= 1'b0;
      bcnt_q  <= '0;
      setp_q  <= 1'b0;
      rstp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      qn_q    <= qn_d;
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
      setp_q  <= set_p;
      rstp_q  <= rst_p;
    end
  end
  always_comb begin
    led               = '0;
    led[LED_Q]        = q_q;
    led[LED_QN]       = qn_q;
    led[LED_CONFLICT] = blink_q;
    led[LED_SETP]     = setp_q;
    led[LED_RSTP]     = rstp_q;
  end
  assign q   = q_q;
  assign q_n = qn_q;
endmodule

// File: tb/tb_btn_latch_ctrl.sv
// tb_btn_latch_ctrl: directed and randomized checks of btn_latch_ctrl against a window-based model
module tb_btn_latch_ctrl;
  localparam int DEB = 4;
  localparam int BH  = 3;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn;
  logic       q, q_n;
  logic [4:0] led;
  int         checks = 0;
  int         errors = 0;
  bit         chk_en = 0;
  btn_latch_ctrl #(.DEB_CYCLES(DEB), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst(rst), .btn(btn), .q(q), .q_n(q_n), .led(led)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [4:0] act, logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: a button's debounced level flips once the last DEB synchronized
  // samples (raw samples delayed two clocks) all disagree with it.
  bit   rq[2][$];
  bit   st[2];
  bit   mem, conf, all_d;
  int   ncf;
  logic exp_q, exp_qn;
  logic [4:0] exp_led;
  logic [1:0] lp;
  always @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        rq[b].delete();
        repeat (DEB + 2) rq[b].push_back(1'b0);
        st[b] = 1'b0;
      end
      mem = 0; conf = 0; ncf = 0; lp = 2'b00;
    end else begin
      if (st[0] && st[1]) conf = 1;
      else if (st[0]) begin mem = 1; conf = 0; end
      else if (st[1]) begin mem = 0; conf = 0; end
      else if (conf) begin mem = 0; conf = 0; end
      ncf = conf ? ncf + 1 : 0;
      lp = {st[1], st[0]};
      for (int b = 0; b < 2; b++) begin
        rq[b].push_back(~btn[b]);
        void'(rq[b].pop_front());
        all_d = 1;
        for (int j = 0; j < DEB; j++) if (rq[b][j] == st[b]) all_d = 0;
        if (all_d) st[b] = ~st[b];
      end
    end
    exp_q  = mem && !conf;
    exp_qn = !mem && !conf;
    exp_led = {lp, conf && (((ncf - 1) / BH) % 2 == 0), exp_qn, exp_q};
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_q", {4'b0, q}, {4'b0, exp_q});
      chk("model_qn", {4'b0, q_n}, {4'b0, exp_qn});
      chk("model_led", led, exp_led);
    end
  end
  int pat[7] = '{1, 1, 1, 0, 0, 0, 1};
  initial begin
    rst = 1'b1;
    btn = 2'b11;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1;
    repeat (20) begin
      @(negedge clk);
      chk("rst_led", led, 5'b00010);
      chk("rst_q", {3'b0, q, q_n}, 5'b00001);
    end
    btn = 2'b10;
    repeat (6) @(negedge clk);
    chk("set_early", {3'b0, q, led[3]}, 5'b00000);
    @(negedge clk);
    chk("set_q", {3'b0, q, q_n}, 5'b00010);
    chk("set_led3", {4'b0, led[3]}, 5'b00001);
    repeat (3) @(negedge clk);
    btn = 2'b11;
    repeat (10) @(negedge clk);
    chk("set_hold", {3'b0, q, led[3]}, 5'b00010);
    repeat (5) begin
      btn = 2'b10;
      repeat (3) begin
        @(negedge clk);
        chk("bounce", {3'b0, q, led[3]}, 5'b00010);
      end
      btn = 2'b11;
      @(negedge clk);
      chk("bounce", {3'b0, q, led[3]}, 5'b00010);
    end
    repeat (8) begin
      @(negedge clk);
      chk("bounce_tail", {3'b0, q, led[3]}, 5'b00010);
    end
    btn = 2'b00;
    repeat (6) @(negedge clk);
    chk("conf_pre", {3'b0, q, q_n}, 5'b00010);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("conf_q", {3'b0, q, q_n}, 5'b00000);
      chk("conf_blink", {4'b0, led[2]}, 5'(pat[i]));
    end
    btn = 2'b11;
    repeat (6) @(negedge clk);
    chk("conf_rel_pre", {3'b0, q, q_n}, 5'b00000);
    @(negedge clk);
    chk("conf_rel", {2'b0, q, q_n, led[2]}, 5'b00010);
    btn = 2'b00;
    repeat (7) @(negedge clk);
    chk("conf2", {2'b0, q, q_n, led[2]}, 5'b00001);
    repeat (2) @(negedge clk);
    btn = 2'b10;
    repeat (6) @(negedge clk);
    chk("rel1_pre", {3'b0, q, q_n}, 5'b00000);
    @(negedge clk);
    chk("rel1", {2'b0, q, q_n, led[2]}, 5'b00100);
    btn = 2'b11;
    repeat (10) @(negedge clk);
    btn = 2'b10;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst", {4'b0, q}, 5'b00000);
    repeat (5) begin
      @(negedge clk);
      chk("mid_rst_hold", {4'b0, q}, 5'b00000);
    end
    repeat (2) @(negedge clk);
    chk("mid_rst_set", {4'b0, q}, 5'b00001);
    for (int i = 0; i < 120; i++) begin
      btn = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 24) == 0);
      @(negedge clk);
      rst = 1'b0;
      repeat ($urandom_range(0, 11)) @(negedge clk);
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
